// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with selectable 60/50 Hz frame totals,
// sync/blank decode, and VBL / line-compare pulses plus a frame parity bit.
module video_timing_gen #(
  parameter int unsigned HW       = 11,
  parameter int unsigned VW       = 10,
  parameter int unsigned H_TOTAL  = 912,
  parameter int unsigned H_VIS    = 704,
  parameter int unsigned H_SS     = 752,
  parameter int unsigned H_SE     = 816,
  parameter int unsigned V_TOT_60 = 262,
  parameter int unsigned V_VBS_60 = 240,
  parameter int unsigned V_SS_60  = 247,
  parameter int unsigned V_SE_60  = 250,
  parameter int unsigned V_TOT_50 = 312,
  parameter int unsigned V_VBS_50 = 288,
  parameter int unsigned V_SS_50  = 295,
  parameter int unsigned V_SE_50  = 298,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          mode_50hz,
  input  logic [VW-1:0] line_cmp,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          mode_act,
  output logic          vbl_irq,
  output logic          line_irq,
  output logic          field
);

  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic          mode_act_q, mode_act_d;
  logic          field_q, field_d;
  logic          vbl_irq_q, vbl_irq_d;
  logic          line_irq_q, line_irq_d;

  logic [VW-1:0] v_tot, v_vbs, v_ss, v_se;
  logic          h_last, v_last;
  logic          hs_act, vs_act;

  // Vertical limits follow the standard latched at the last frame start.
  always_comb begin
    if (mode_act_q) begin
      v_tot = VW'(V_TOT_50);
      v_vbs = VW'(V_VBS_50);
      v_ss  = VW'(V_SS_50);
      v_se  = VW'(V_SE_50);
    end else begin
      v_tot = VW'(V_TOT_60);
      v_vbs = VW'(V_VBS_60);
      v_ss  = VW'(V_SS_60);
      v_se  = VW'(V_SE_60);
    end
  end

  assign h_last = (hpos_q >= HW'(H_TOTAL - 1));
  assign v_last = (vpos_q >= (v_tot - VW'(1)));

  always_comb begin
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    mode_act_d = mode_act_q;
    field_d    = field_q;
    vbl_irq_d  = 1'b0;
    line_irq_d = 1'b0;
    if (ce_pix) begin
      if (h_last) begin
        hpos_d = '0;
        if (v_last) begin
          vpos_d     = '0;
          mode_act_d = mode_50hz;
          field_d    = ~field_q;
        end else begin
          vpos_d = vpos_q + VW'(1);
        end
        // Pulses key off the line being entered; an out-of-range line_cmp never matches.
        vbl_irq_d  = (vpos_d == v_vbs);
        line_irq_d = (vpos_d == line_cmp);
      end else begin
        hpos_d = hpos_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      hpos_q     <= '0;
      vpos_q     <= '0;
      mode_act_q <= 1'b0;
      field_q    <= 1'b0;
      vbl_irq_q  <= 1'b0;
      line_irq_q <= 1'b0;
    end else begin
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      mode_act_q <= mode_act_d;
      field_q    <= field_d;
      vbl_irq_q  <= vbl_irq_d;
      line_irq_q <= line_irq_d;
    end
  end

  assign hs_act = (hpos_q >= HW'(H_SS)) && (hpos_q < HW'(H_SE));
  assign vs_act = (vpos_q >= v_ss) && (vpos_q < v_se);

  assign hsync    = SYNC_POL ? hs_act : ~hs_act;
  assign vsync    = SYNC_POL ? vs_act : ~vs_act;
  assign hblank   = (hpos_q >= HW'(H_VIS));
  assign vblank   = (vpos_q >= v_vbs);
  assign hpos     = hpos_q;
  assign vpos     = vpos_q;
  assign mode_act = mode_act_q;
  assign field    = field_q;
  assign vbl_irq  = vbl_irq_q;
  assign line_irq = line_irq_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the IIgs video path. It replaces the fixed NTSC counter with a generator that supports runtime-selectable 60 Hz (262-line) and 50 Hz (312-line) frames, exact totals and configurable sync polarity. It also produces per-frame events consumed by the VGC interrupt logic and the scan-out engine: a VBL-start pulse, a programmable line-compare pulse and a frame parity bit. It sits between the pixel clock enable and the video shifter / scaler.

## Interface
Parameters:
- HW, 11: horizontal counter width.
- VW, 10: vertical counter width.
- H_TOTAL, 912: pixels per line; counter range 0..H_TOTAL-1.
- H_VIS, 704: first hblank pixel (32 border + 640 active + 32 border).
- H_SS, 752: first hsync pixel.
- H_SE, 816: first pixel after hsync.
- V_TOT_60 / V_VBS_60 / V_SS_60 / V_SE_60, 262 / 240 / 247 / 250: 60 Hz line total, first vblank line, first vsync line, first line after vsync.
- V_TOT_50 / V_VBS_50 / V_SS_50 / V_SE_50, 312 / 288 / 295 / 298: same values for 50 Hz.
- SYNC_POL, 0: 0 = active-low syncs, 1 = active-high.

Ports:
- clk_vid, in, 1: video clock.
- reset, in, 1: asynchronous, active-high.
- ce_pix, in, 1: pixel clock enable; counters advance only on clk_vid edges with ce_pix=1.
- mode_50hz, in, 1: requested frame standard; sampled only at frame start.
- line_cmp, in, VW: line number for line_irq.
- hsync, out, 1; vsync, out, 1: syncs at SYNC_POL.
- hblank, out, 1; vblank, out, 1: blanking, active-high.
- hpos, out, HW; vpos, out, VW: current counters.
- mode_act, out, 1: standard in force for the current frame.
- vbl_irq, out, 1: one-clk_vid pulse at vblank start.
- line_irq, out, 1: one-clk_vid pulse at start of line line_cmp.
- field, out, 1: toggles every frame.

## Operation
- hpos increments on each ce_pix. At H_TOTAL-1 it wraps to 0 and vpos advances.
- vpos wraps from V_TOT-1 to 0, where V_TOT is chosen by mode_act.
- Frame start is the ce_pix edge at which (hpos, vpos) becomes (0, 0). On that edge mode_act <= mode_50hz and field toggles. Changing mode_50hz mid-frame has no effect until the next frame start.
- Comparisons are made on the registered counters, with half-open intervals:
  - hblank = hpos >= H_VIS.
  - hsync active when H_SS <= hpos < H_SE.
  - vblank = vpos >= V_VBS.
  - vsync active when V_SS <= vpos < V_SE.
- A mode switch always enters line 0 cleanly, so a frame never uses a mixed V_TOT.
- vbl_irq is high for exactly one clk_vid cycle: the cycle after the ce_pix edge at which (hpos, vpos) becomes (0, V_VBS).
- line_irq follows the same rule at (0, line_cmp).
  - If line_cmp >= V_TOT of the active mode, line_irq never fires.
  - If line_cmp equals V_VBS, both pulses fire in the same cycle.
- line_cmp is sampled on the transition edge itself; changing it mid-line affects only future transitions.
- Reset values: hpos=0, vpos=0, mode_act=0, field=0, vbl_irq=0, line_irq=0, hblank=0, vblank=0, hsync=vsync=inactive level (~SYNC_POL).
- Reset forces these values immediately and asynchronously, including mid-frame. Counting resumes on the first ce_pix after reset deasserts. The reset state is not a frame start, so field does not toggle.

## Timing
- Counters, mode_act, field, vbl_irq and line_irq are registered.
- hsync/hblank/vsync/vblank are combinational from the registered counters and change in the same cycle as hpos/vpos.
- Pulses lag the counter transition by one clk_vid cycle. They deassert on the next clk_vid edge regardless of ce_pix.
- ce_pix=0: all state holds, and no pulses are generated.
- 60 Hz frame: 912 × 262 = 238 944 ce_pix. 50 Hz frame: 912 × 312 = 284 544 ce_pix.

## Test plan
- Reset, apply ce_pix every cycle for one 60 Hz line -> hpos 0..911 then 0.
  - hblank rises at hpos=704.
  - hsync is low exactly for hpos 752..815 (64 pixels).
  - vpos is 1 after 912 ce_pix.
- Run a full 60 Hz frame ->
  - vblank rises at vpos=240.
  - vsync is low for lines 247..249.
  - vpos wraps from 261 to 0.
  - vbl_irq fires once, 1 cycle wide, the cycle after (0, 240).
  - field toggles at wrap.
- Set mode_50hz=1 at vpos=100 ->
  - the current frame still wraps at 261.
  - mode_act rises at frame start.
  - the next frame wraps from 311, with vblank at 288 and vsync on lines 295..297.
- line_cmp=240 -> line_irq and vbl_irq pulse in the same cycle. line_cmp=300 in 60 Hz mode -> no line_irq for a whole frame.
- ce_pix toggled 1-in-4 -> hpos advances once per 4 cycles, and each pulse is still exactly one clk_vid cycle.
- Assert reset at (hpos=500, vpos=120) -> all outputs return to reset values asynchronously. After release, the first ce_pix gives hpos=1, and field stays 0.
- SYNC_POL=1 build -> hsync high for hpos 752..815 and low in reset.
